// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the LEGv8 datapath: fetch/decode/execute/memory/write-back
// sequencing, datapath strobes, immediate-extension select, retire counter and illegal-opcode trap.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [10:0]      i_opcode,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_PCWrite,
    output logic             o_PCSrc,
    output logic             o_IorD,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic             o_IRWrite,
    output logic             o_RegWrite,
    output logic             o_MemtoReg,
    output logic             o_Reg2Loc,
    output logic             o_ALUSrcA,
    output logic [1:0]       o_ALUSrcB,
    output logic [1:0]       o_ALUOp,
    output logic [1:0]       o_SEU,
    output logic [3:0]       o_state,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        CBRANCH  = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t           state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    logic is_r, is_i, is_ldur, is_stur, is_b, is_cbz;

    assign is_r    = (i_opcode == 11'b10001011000) || (i_opcode == 11'b11001011000) ||
                     (i_opcode == 11'b10001010000) || (i_opcode == 11'b10101010000);
    assign is_i    = (i_opcode[10:1] == 10'b1001000100) || (i_opcode[10:1] == 10'b1101000100);
    assign is_ldur = (i_opcode == 11'b11111000010);
    assign is_stur = (i_opcode == 11'b11111000000);
    assign is_b    = (i_opcode[10:5] == 6'b000101);
    assign is_cbz  = (i_opcode[10:3] == 8'b10110100);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                FETCH:    if (i_mem_ready) state <= DECODE;
                DECODE: begin
                    if (is_r)                   state <= EXEC_R;
                    else if (is_i)              state <= EXEC_I;
                    else if (is_ldur || is_stur) state <= MEM_ADDR;
                    else if (is_b)              state <= BRANCH;
                    else if (is_cbz)            state <= CBRANCH;
                    else begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end
                end
                EXEC_R, EXEC_I: state <= ALU_WB;
                MEM_ADDR: state <= is_ldur ? MEM_RD : MEM_WR;
                MEM_RD:   if (i_mem_ready) state <= MEM_WB;
                MEM_WR: begin
                    if (i_mem_ready) begin
                        state   <= FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                ALU_WB, MEM_WB, BRANCH, CBRANCH: begin
                    state   <= FETCH;
                    retired <= retired + CNT_W'(1);
                end
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Strobes are a decode of the current state; reset forces every output low.
    always_comb begin
        o_PCWrite  = 1'b0;
        o_PCSrc    = 1'b0;
        o_IorD     = 1'b0;
        o_MemRead  = 1'b0;
        o_MemWrite = 1'b0;
        o_IRWrite  = 1'b0;
        o_RegWrite = 1'b0;
        o_MemtoReg = 1'b0;
        o_ALUSrcA  = 1'b0;
        o_ALUSrcB  = 2'b00;
        o_ALUOp    = 2'b00;
        o_SEU      = 2'd0;
        o_Reg2Loc  = 1'b0;
        if (!i_rst) begin
            if (is_ldur || is_stur) o_SEU = 2'd1;
            else if (is_b)          o_SEU = 2'd2;
            else if (is_cbz)        o_SEU = 2'd3;
            o_Reg2Loc = is_stur || is_cbz;
            case (state)
                FETCH: begin
                    o_MemRead = 1'b1;
                    o_ALUSrcB = 2'b01;
                    o_IRWrite = i_mem_ready;
                    o_PCWrite = i_mem_ready;
                end
                DECODE:   o_ALUSrcB = 2'b11;
                EXEC_R: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUOp   = 2'b10;
                end
                EXEC_I: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUSrcB = 2'b10;
                    o_ALUOp   = 2'b10;
                end
                ALU_WB:   o_RegWrite = 1'b1;
                MEM_ADDR: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUSrcB = 2'b10;
                end
                MEM_RD: begin
                    o_MemRead = 1'b1;
                    o_IorD    = 1'b1;
                end
                MEM_WB: begin
                    o_RegWrite = 1'b1;
                    o_MemtoReg = 1'b1;
                end
                MEM_WR: begin
                    o_MemWrite = 1'b1;
                    o_IorD     = 1'b1;
                end
                BRANCH: begin
                    o_PCWrite = 1'b1;
                    o_PCSrc   = 1'b1;
                end
                CBRANCH: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUOp   = 2'b01;
                    o_PCSrc   = 1'b1;
                    o_PCWrite = i_zero;
                end
                default: ;
            endcase
        end
    end

    assign o_state   = state;
    assign o_illegal = illegal;
    assign o_retired = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expectations queued at drive time, popped and compared
// shortly after; table of single instructions plus hand sequences for waits, reset, trap and wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode;
    logic        zero, mem_ready;
    logic        pcwrite, pcsrc, iord, memread, memwrite, irwrite, regwrite, memtoreg;
    logic        reg2loc, alusrca, illegal;
    logic [1:0]  alusrcb, aluop, seu;
    logic [3:0]  state;
    logic [3:0]  retired;

    multicycle_control #(.CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_PCWrite(pcwrite), .o_PCSrc(pcsrc), .o_IorD(iord), .o_MemRead(memread),
        .o_MemWrite(memwrite), .o_IRWrite(irwrite), .o_RegWrite(regwrite), .o_MemtoReg(memtoreg),
        .o_Reg2Loc(reg2loc), .o_ALUSrcA(alusrca), .o_ALUSrcB(alusrcb), .o_ALUOp(aluop),
        .o_SEU(seu), .o_state(state), .o_illegal(illegal), .o_retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] ctl;
        logic [1:0]  seu;
        logic        r2l;
        logic        ill;
        logic [3:0]  ret;
    } exp_t;

    typedef struct {
        string       name;
        logic [10:0] op;
        logic        z;
        int          len;
        logic [31:0] seq;
        logic [1:0]  seu;
        logic        r2l;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[11];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  ret_model;
    logic        ill_model;
    logic [10:0] cur_op;
    logic [1:0]  cur_seu;
    logic        cur_r2l;

    // Control bundle order: PCWrite PCSrc IorD MemRead MemWrite IRWrite RegWrite MemtoReg ALUSrcA ALUSrcB ALUOp
    function automatic logic [12:0] ctl_for(input logic [3:0] st, input logic rdy, input logic z);
        logic pcw, pcs, iod, mrd, mwr, irw, rw, m2r, sa;
        logic [1:0] sb, ao;
        pcw = 0; pcs = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; m2r = 0; sa = 0;
        sb = 2'b00; ao = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; ao = 2'b10; end
            4'd3:  begin sa = 1; sb = 2'b10; ao = 2'b10; end
            4'd4:  rw = 1;
            4'd5:  begin sa = 1; sb = 2'b10; end
            4'd6:  begin mrd = 1; iod = 1; end
            4'd7:  begin rw = 1; m2r = 1; end
            4'd8:  begin mwr = 1; iod = 1; end
            4'd9:  begin pcw = 1; pcs = 1; end
            4'd10: begin sa = 1; ao = 2'b01; pcs = 1; pcw = z; end
            default: ;
        endcase
        return {pcw, pcs, iod, mrd, mwr, irw, rw, m2r, sa, sb, ao};
    endfunction

    task automatic check(input string tag);
        exp_t e;
        logic [12:0] ctl;
        e = q.pop_front();
        ctl = {pcwrite, pcsrc, iord, memread, memwrite, irwrite, regwrite, memtoreg,
               alusrca, alusrcb, aluop};
        checks++;
        if (state !== e.st) begin errors++; $display("FAIL %s state got %0d want %0d", tag, state, e.st); end
        checks++;
        if (ctl !== e.ctl) begin errors++; $display("FAIL %s ctl (st %0d) got %b want %b", tag, e.st, ctl, e.ctl); end
        checks++;
        if (seu !== e.seu) begin errors++; $display("FAIL %s seu got %0d want %0d", tag, seu, e.seu); end
        checks++;
        if (reg2loc !== e.r2l) begin errors++; $display("FAIL %s reg2loc got %b want %b", tag, reg2loc, e.r2l); end
        checks++;
        if (illegal !== e.ill) begin errors++; $display("FAIL %s illegal got %b want %b", tag, illegal, e.ill); end
        checks++;
        if (retired !== e.ret) begin errors++; $display("FAIL %s retired got %0d want %0d", tag, retired, e.ret); end
    endtask

    // One clock of an instruction: drive at negedge, expect state st, compare 1ns later.
    task automatic step(input string tag, input logic [3:0] st, input logic rdy, input logic z,
                        input logic fin);
        exp_t e;
        @(negedge clk);
        opcode = cur_op; mem_ready = rdy; zero = z;
        if (st == 4'd11) ill_model = 1'b1;
        e.st = st; e.ctl = ctl_for(st, rdy, z); e.seu = cur_seu; e.r2l = cur_r2l;
        e.ill = ill_model; e.ret = ret_model;
        q.push_back(e);
        #1 check(tag);
        if (fin) ret_model = ret_model + 4'd1;
    endtask

    // Assert reset immediately (asynchronously), check the quiet outputs, release on a negedge.
    task automatic do_reset(input string tag);
        exp_t e;
        rst = 1'b1;
        ret_model = 4'd0; ill_model = 1'b0;
        e = '0;
        q.push_back(e);
        #1 check(tag);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        cur_op = v.op; cur_seu = v.seu; cur_r2l = v.r2l;
        for (int i = 0; i < v.len; i++)
            step(v.name, v.seq[4*i +: 4], 1'b1, v.z, i == v.len - 1);
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        ret_model = 4'd0; ill_model = 1'b0;
        cur_op = '0; cur_seu = 2'd0; cur_r2l = 1'b0;

        vecs[0]  = '{"ADD",  11'b10001011000, 1'b0, 4, 32'h0000_4210, 2'd0, 1'b0};
        vecs[1]  = '{"SUB",  11'b11001011000, 1'b0, 4, 32'h0000_4210, 2'd0, 1'b0};
        vecs[2]  = '{"AND",  11'b10001010000, 1'b0, 4, 32'h0000_4210, 2'd0, 1'b0};
        vecs[3]  = '{"ORR",  11'b10101010000, 1'b0, 4, 32'h0000_4210, 2'd0, 1'b0};
        vecs[4]  = '{"ADDI", 11'b10010001001, 1'b0, 4, 32'h0000_4310, 2'd0, 1'b0};
        vecs[5]  = '{"SUBI", 11'b11010001000, 1'b1, 4, 32'h0000_4310, 2'd0, 1'b0};
        vecs[6]  = '{"LDUR", 11'b11111000010, 1'b0, 5, 32'h0007_6510, 2'd1, 1'b0};
        vecs[7]  = '{"STUR", 11'b11111000000, 1'b0, 4, 32'h0000_8510, 2'd1, 1'b1};
        vecs[8]  = '{"B",    11'b00010110101, 1'b0, 3, 32'h0000_0910, 2'd2, 1'b0};
        vecs[9]  = '{"CBZ0", 11'b10110100101, 1'b0, 3, 32'h0000_0A10, 2'd3, 1'b1};
        vecs[10] = '{"CBZ1", 11'b10110100101, 1'b1, 3, 32'h0000_0A10, 2'd3, 1'b1};

        #3 do_reset("por");

        for (int k = 0; k < 11; k++) run_vec(vecs[k]);

        // Reset during a stalled MEM_RD aborts without retiring; LDUR restarts from FETCH.
        cur_op = 11'b11111000010; cur_seu = 2'd1; cur_r2l = 1'b0;
        step("ldur_abort", 4'd0, 1'b1, 1'b0, 1'b0);
        step("ldur_abort", 4'd1, 1'b1, 1'b0, 1'b0);
        step("ldur_abort", 4'd5, 1'b1, 1'b0, 1'b0);
        step("ldur_abort", 4'd6, 1'b0, 1'b0, 1'b0);
        #2 do_reset("mid_memrd_reset");
        step("ldur_wait", 4'd0, 1'b0, 1'b0, 1'b0);
        step("ldur_wait", 4'd0, 1'b1, 1'b0, 1'b0);
        step("ldur_wait", 4'd1, 1'b0, 1'b0, 1'b0);
        step("ldur_wait", 4'd5, 1'b0, 1'b0, 1'b0);
        step("ldur_wait", 4'd6, 1'b0, 1'b0, 1'b0);
        step("ldur_wait", 4'd6, 1'b0, 1'b0, 1'b0);
        step("ldur_wait", 4'd6, 1'b1, 1'b0, 1'b0);
        step("ldur_wait", 4'd7, 1'b0, 1'b0, 1'b1);

        // STUR with one stalled write cycle.
        cur_op = 11'b11111000000; cur_seu = 2'd1; cur_r2l = 1'b1;
        step("stur_wait", 4'd0, 1'b1, 1'b0, 1'b0);
        step("stur_wait", 4'd1, 1'b1, 1'b0, 1'b0);
        step("stur_wait", 4'd5, 1'b1, 1'b0, 1'b0);
        step("stur_wait", 4'd8, 1'b0, 1'b0, 1'b0);
        step("stur_wait", 4'd8, 1'b1, 1'b0, 1'b1);

        // Illegal opcode traps and holds until reset.
        cur_op = 11'b00000000000; cur_seu = 2'd0; cur_r2l = 1'b0;
        step("illegal", 4'd0, 1'b1, 1'b0, 1'b0);
        step("illegal", 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++)
            step("trap_hold", 4'd11, i[0], i[1], 1'b0);
        #2 do_reset("trap_reset");
        run_vec(vecs[0]);

        // Sixteen branches with random offset bits wrap the 4-bit counter.
        cur_seu = 2'd2; cur_r2l = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cur_op = {6'b000101, 5'($urandom_range(0, 31))};
            step("b_wrap", 4'd0, 1'b1, 1'b0, 1'b0);
            step("b_wrap", 4'd1, 1'b1, 1'b0, 1'b0);
            step("b_wrap", 4'd9, 1'b1, 1'b0, 1'b1);
        end
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
